// File: rtl/ram_port_ctrl_pkg.sv
// Shared definitions for the dual-port RAM front-end: geometry defaults common
// with the RAM macro and the same-address hazard helper.
package ram_port_ctrl_pkg;

    localparam int RAM_ADDR_W = 8;
    localparam int RAM_DATA_W = 8;

    // A fetch read colliding with a same-cycle store must wait so it observes the new data.
    function automatic logic fetch_store_clash(
        input logic st_acc,
        input logic [RAM_ADDR_W-1:0] fe_addr,
        input logic [RAM_ADDR_W-1:0] ls_addr
    );
        return st_acc & (fe_addr == ls_addr);
    endfunction

endpackage

// File: rtl/ram_port_ctrl_if.sv
// Fetch / load-store request-response buses plus the RAM-side connection.
interface ram_port_ctrl_if
    import ram_port_ctrl_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
);
    logic              fe_req_valid;
    logic              fe_req_ready;
    logic [ADDR_W-1:0] fe_req_addr;
    logic              fe_rsp_valid;
    logic              fe_rsp_ready;
    logic [DATA_W-1:0] fe_rsp_data;

    logic              ls_req_valid;
    logic              ls_req_ready;
    logic              ls_req_we;
    logic [ADDR_W-1:0] ls_req_addr;
    logic [DATA_W-1:0] ls_req_wdata;
    logic              ls_rsp_valid;
    logic              ls_rsp_ready;
    logic [DATA_W-1:0] ls_rsp_data;

    logic [ADDR_W-1:0] ram_addr1;
    logic [ADDR_W-1:0] ram_addr2;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_dout1;
    logic [DATA_W-1:0] ram_dout2;

    modport slave (
        input  fe_req_valid, fe_req_addr, fe_rsp_ready,
        input  ls_req_valid, ls_req_we, ls_req_addr, ls_req_wdata, ls_rsp_ready,
        input  ram_dout1, ram_dout2,
        output fe_req_ready, fe_rsp_valid, fe_rsp_data,
        output ls_req_ready, ls_rsp_valid, ls_rsp_data,
        output ram_addr1, ram_addr2, ram_we, ram_wdata
    );

    modport master (
        output fe_req_valid, fe_req_addr, fe_rsp_ready,
        output ls_req_valid, ls_req_we, ls_req_addr, ls_req_wdata, ls_rsp_ready,
        output ram_dout1, ram_dout2,
        input  fe_req_ready, fe_rsp_valid, fe_rsp_data,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
        input  ram_addr1, ram_addr2, ram_we, ram_wdata
    );

endinterface

// File: rtl/ram_rsp_slot.sv
// Per-port response slot: tracks a read issued last cycle and parks its data
// in a single-entry hold register when the consumer back-pressures.
module ram_rsp_slot
    import ram_port_ctrl_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_i,
    input  logic              rsp_ready_i,
    input  logic [DATA_W-1:0] ram_dout_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              req_ready_o
);

    logic              inflight_q, inflight_d;
    logic              hold_v_q, hold_v_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    // Next-state: RAM data is only valid for one cycle, so capture it if it cannot leave now.
    always_comb begin
        inflight_d = issue_i;
        hold_v_d   = hold_v_q;
        hold_d     = hold_q;
        if (inflight_q && !rsp_ready_i) begin
            hold_v_d = 1'b1;
            hold_d   = ram_dout_i;
        end else if (hold_v_q && rsp_ready_i) begin
            hold_v_d = 1'b0;
        end else begin
            hold_v_d = hold_v_q;
        end
    end

    // Slot state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            hold_v_q   <= 1'b0;
            hold_q     <= {DATA_W{1'b0}};
        end else begin
            inflight_q <= inflight_d;
            hold_v_q   <= hold_v_d;
            hold_q     <= hold_d;
        end
    end

    // Response and back-pressure outputs, forced quiet while in reset.
    always_comb begin
        if (rst) begin
            rsp_valid_o = 1'b0;
            rsp_data_o  = {DATA_W{1'b0}};
            req_ready_o = 1'b0;
        end else begin
            rsp_valid_o = inflight_q | hold_v_q;
            if (hold_v_q) begin
                rsp_data_o = hold_q;
            end else if (inflight_q) begin
                rsp_data_o = ram_dout_i;
            end else begin
                rsp_data_o = {DATA_W{1'b0}};
            end
            req_ready_o = ~hold_v_q & ~(inflight_q & ~rsp_ready_i);
        end
    end

endmodule

// File: rtl/ram_port_ctrl.sv
// Two-port RAM front-end: fetch reads on port 1, loads/stores on port 2, with
// one-cycle read latency and per-port response hold.
module ram_port_ctrl
    import ram_port_ctrl_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic            clk,
    input  logic            rst,
    ram_port_ctrl_if.slave  bus
);

    logic              fe_slot_rdy_s, ls_slot_rdy_s;
    logic              fe_acc_s, ls_acc_s, st_acc_s, ld_acc_s, clash_s;
    logic              fe_rsp_valid_s, ls_rsp_valid_s;
    logic [DATA_W-1:0] fe_rsp_data_s, ls_rsp_data_s;
    logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;

    assign st_acc_s = bus.ls_req_valid & bus.ls_req_we & bus.ls_req_ready;
    assign clash_s  = fetch_store_clash(st_acc_s, bus.fe_req_addr, bus.ls_req_addr);

    assign bus.fe_req_ready = ~rst & fe_slot_rdy_s & ~clash_s;
    assign bus.ls_req_ready = ~rst & ls_slot_rdy_s;
    assign fe_acc_s = bus.fe_req_valid & bus.fe_req_ready;
    assign ls_acc_s = bus.ls_req_valid & bus.ls_req_ready;
    assign ld_acc_s = ls_acc_s & ~bus.ls_req_we;

    // The accepted address is presented in the acceptance cycle and held afterwards.
    always_comb begin
        addr1_d = fe_acc_s ? bus.fe_req_addr : addr1_q;
        addr2_d = ls_acc_s ? bus.ls_req_addr : addr2_q;
        if (rst) begin
            bus.ram_addr1 = {ADDR_W{1'b0}};
            bus.ram_addr2 = {ADDR_W{1'b0}};
            bus.ram_we    = 1'b0;
            bus.ram_wdata = {DATA_W{1'b0}};
        end else begin
            bus.ram_addr1 = addr1_d;
            bus.ram_addr2 = addr2_d;
            bus.ram_we    = st_acc_s;
            bus.ram_wdata = st_acc_s ? bus.ls_req_wdata : {DATA_W{1'b0}};
        end
    end

    // Last-issued address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr1_q <= {ADDR_W{1'b0}};
            addr2_q <= {ADDR_W{1'b0}};
        end else begin
            addr1_q <= addr1_d;
            addr2_q <= addr2_d;
        end
    end

    ram_rsp_slot #(.DATA_W(DATA_W)) u_fe_slot (
        .clk         (clk),
        .rst         (rst),
        .issue_i     (fe_acc_s),
        .rsp_ready_i (bus.fe_rsp_ready),
        .ram_dout_i  (bus.ram_dout1),
        .rsp_valid_o (fe_rsp_valid_s),
        .rsp_data_o  (fe_rsp_data_s),
        .req_ready_o (fe_slot_rdy_s)
    );

    // Stores never occupy the load/store slot, so only loads produce a response.
    ram_rsp_slot #(.DATA_W(DATA_W)) u_ls_slot (
        .clk         (clk),
        .rst         (rst),
        .issue_i     (ld_acc_s),
        .rsp_ready_i (bus.ls_rsp_ready),
        .ram_dout_i  (bus.ram_dout2),
        .rsp_valid_o (ls_rsp_valid_s),
        .rsp_data_o  (ls_rsp_data_s),
        .req_ready_o (ls_slot_rdy_s)
    );

    assign bus.fe_rsp_valid = fe_rsp_valid_s;
    assign bus.fe_rsp_data  = fe_rsp_data_s;
    assign bus.ls_rsp_valid = ls_rsp_valid_s;
    assign bus.ls_rsp_data  = ls_rsp_data_s;

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Directed self-checking bench for ram_port_ctrl with a behavioural registered-read RAM.
module tb_ram_port_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [7:0] mem [256];
    logic [7:0] rsp_q [$];

    ram_port_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    ram_port_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] preload(input int a);
        case (a)
            8'h00:   return 8'h11;
            8'h01:   return 8'h22;
            8'h02:   return 8'h33;
            8'h03:   return 8'h44;
            8'h10:   return 8'hA5;
            8'h40:   return 8'h99;
            default: return 8'h00;
        endcase
    endfunction

    // RAM model: registered reads, write on port 2 address, contents restored in reset.
    always @(posedge clk) begin
        bus.ram_dout1 <= mem[bus.ram_addr1];
        bus.ram_dout2 <= mem[bus.ram_addr2];
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= preload(i);
        end else if (bus.ram_we) begin
            mem[bus.ram_addr2] <= bus.ram_wdata;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        int  n;
        logic acc;
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus.fe_req_valid = 1'b0; bus.fe_req_addr = 8'h00; bus.fe_rsp_ready = 1'b1;
        bus.ls_req_valid = 1'b0; bus.ls_req_we = 1'b0; bus.ls_req_addr = 8'h00;
        bus.ls_req_wdata = 8'h00; bus.ls_rsp_ready = 1'b1;

        // Reset state
        mid();
        check_eq("rst_fe_ready", bus.fe_req_ready, 0);
        check_eq("rst_ls_ready", bus.ls_req_ready, 0);
        check_eq("rst_we", bus.ram_we, 0);
        check_eq("rst_addr1", bus.ram_addr1, 0);
        check_eq("rst_fe_valid", bus.fe_rsp_valid, 0);
        check_eq("rst_fe_data", bus.fe_rsp_data, 0);
        step();
        rst = 1'b0;
        mid();
        check_eq("post_rst_fe_ready", bus.fe_req_ready, 1);
        check_eq("post_rst_ls_ready", bus.ls_req_ready, 1);

        // Single fetch of preloaded 0x10
        step();
        bus.fe_req_valid = 1'b1; bus.fe_req_addr = 8'h10;
        mid();
        check_eq("f1_ready", bus.fe_req_ready, 1);
        check_eq("f1_addr1", bus.ram_addr1, 32'h10);
        step();
        bus.fe_req_valid = 1'b0; bus.fe_req_addr = 8'h55;
        mid();
        check_eq("f1_rsp_valid", bus.fe_rsp_valid, 1);
        check_eq("f1_rsp_data", bus.fe_rsp_data, 32'hA5);
        check_eq("f1_ready_held", bus.fe_req_ready, 1);
        step();
        mid();
        check_eq("f1_rsp_done", bus.fe_rsp_valid, 0);
        check_eq("f1_addr1_hold", bus.ram_addr1, 32'h10);

        // Fetch stream 0..3 with consumer stalled in cycles 2..4
        n = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            bus.fe_rsp_ready = !(c >= 2 && c <= 4);
            bus.fe_req_valid = (n < 4);
            bus.fe_req_addr  = 8'(n);
            mid();
            if (c >= 2 && c <= 4) begin
                check_eq("st_ready_low", bus.fe_req_ready, 0);
                check_eq("st_valid_held", bus.fe_rsp_valid, 1);
                check_eq("st_data_held", bus.fe_rsp_data, 32'h22);
            end
            acc = bus.fe_req_valid & bus.fe_req_ready;
            if (bus.fe_rsp_valid && bus.fe_rsp_ready) rsp_q.push_back(bus.fe_rsp_data);
            if (acc) n++;
        end
        check_eq("st_rsp_count", rsp_q.size(), 4);
        for (int i = 0; i < 4 && i < rsp_q.size(); i++)
            check_eq("st_rsp_order", rsp_q[i], {24'h0, preload(i)});

        // Store then load to the same address
        step();
        bus.fe_req_valid = 1'b0; bus.fe_rsp_ready = 1'b1;
        bus.ls_req_valid = 1'b1; bus.ls_req_we = 1'b1; bus.ls_req_addr = 8'h20;
        bus.ls_req_wdata = 8'h3C;
        mid();
        check_eq("sl_st_ready", bus.ls_req_ready, 1);
        check_eq("sl_we_on", bus.ram_we, 1);
        check_eq("sl_wdata", bus.ram_wdata, 32'h3C);
        check_eq("sl_addr2", bus.ram_addr2, 32'h20);
        step();
        bus.ls_req_we = 1'b0; bus.ls_req_wdata = 8'h00;
        mid();
        check_eq("sl_we_off", bus.ram_we, 0);
        check_eq("sl_no_st_rsp", bus.ls_rsp_valid, 0);
        check_eq("sl_ld_ready", bus.ls_req_ready, 1);
        step();
        bus.ls_req_valid = 1'b0;
        mid();
        check_eq("sl_ld_valid", bus.ls_rsp_valid, 1);
        check_eq("sl_ld_data", bus.ls_rsp_data, 32'h3C);
        step();
        mid();
        check_eq("sl_ld_done", bus.ls_rsp_valid, 0);

        // Same-cycle fetch and store to 0x40
        step();
        bus.fe_req_valid = 1'b1; bus.fe_req_addr = 8'h40;
        bus.ls_req_valid = 1'b1; bus.ls_req_we = 1'b1; bus.ls_req_addr = 8'h40;
        bus.ls_req_wdata = 8'h77;
        mid();
        check_eq("cl_fe_stall", bus.fe_req_ready, 0);
        check_eq("cl_ls_ready", bus.ls_req_ready, 1);
        check_eq("cl_we", bus.ram_we, 1);
        step();
        bus.ls_req_valid = 1'b0; bus.ls_req_we = 1'b0;
        mid();
        check_eq("cl_fe_ready", bus.fe_req_ready, 1);
        check_eq("cl_no_early_rsp", bus.fe_rsp_valid, 0);
        step();
        bus.fe_req_valid = 1'b0;
        mid();
        check_eq("cl_rsp_valid", bus.fe_rsp_valid, 1);
        check_eq("cl_rsp_data", bus.fe_rsp_data, 32'h77);

        // Reset with a fetch in flight and a load held
        step();
        bus.ls_req_valid = 1'b1; bus.ls_req_addr = 8'h10; bus.ls_rsp_ready = 1'b0;
        step();
        bus.ls_req_valid = 1'b0;
        bus.fe_req_valid = 1'b1; bus.fe_req_addr = 8'h01;
        mid();
        check_eq("rr_ld_inflight", bus.ls_rsp_valid, 1);
        check_eq("rr_fe_accept", bus.fe_req_ready, 1);
        step();
        bus.fe_req_valid = 1'b0;
        rst = 1'b1;
        mid();
        check_eq("rr_fe_valid", bus.fe_rsp_valid, 0);
        check_eq("rr_ls_valid", bus.ls_rsp_valid, 0);
        check_eq("rr_we", bus.ram_we, 0);
        check_eq("rr_addr2", bus.ram_addr2, 0);
        check_eq("rr_ls_ready", bus.ls_req_ready, 0);
        step();
        step();
        rst = 1'b0;
        bus.ls_rsp_ready = 1'b1; bus.fe_rsp_ready = 1'b1;
        mid();
        check_eq("rr_post_fe_valid", bus.fe_rsp_valid, 0);
        check_eq("rr_post_ls_valid", bus.ls_rsp_valid, 0);
        check_eq("rr_post_ls_ready", bus.ls_req_ready, 1);
        step();
        mid();
        check_eq("rr_late_fe_valid", bus.fe_rsp_valid, 0);
        check_eq("rr_late_ls_valid", bus.ls_rsp_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
